// File: rtl/cellrv32_package.sv
// Shared definitions for the CPU-side co-processor dispatch logic.
package cellrv32_package;

    // Dispatch FSM states.
    typedef enum logic [1:0] {
        DISP_IDLE = 2'd0,
        DISP_EXEC = 2'd1,
        DISP_CAPT = 2'd2
    } dispatch_state_t;

    // Width of the co-processor select field coming from the control unit.
    localparam int CP_ID_W = 4;

    // Co-processor slot assignment on the dispatch bus.
    localparam logic [CP_ID_W-1:0] CP_SEL_SHIFT    = 4'd0;
    localparam logic [CP_ID_W-1:0] CP_SEL_MULDIV   = 4'd1;
    localparam logic [CP_ID_W-1:0] CP_SEL_BITMANIP = 4'd2;
    localparam logic [CP_ID_W-1:0] CP_SEL_COND     = 4'd3;
    localparam logic [CP_ID_W-1:0] CP_SEL_SHA      = 4'd4;
    localparam logic [CP_ID_W-1:0] CP_SEL_FPU      = 4'd5;
    localparam logic [CP_ID_W-1:0] CP_SEL_CUSTOM0  = 4'd6;
    localparam logic [CP_ID_W-1:0] CP_SEL_CUSTOM1  = 4'd7;

endpackage

// File: rtl/cellrv32_cpu_cp_dispatch_if.sv
// Signal bundle between the control unit, the dispatcher and the co-processor array.
//
// Handshake: the control unit pulses req_i (with cp_id_i) only while busy_o is low;
// the dispatcher answers with exactly one of done_o / timeout_o / illegal_o as a
// single-cycle pulse, unless kill_i aborts the operation first. Towards the
// co-processors, cp_start_o is a one-cycle one-hot pulse and the selected unit
// raises its cp_valid_i bit for one cycle; its result is captured one cycle later.
interface cellrv32_cpu_cp_dispatch_if #(
    parameter int XLEN   = 32,
    parameter int NUM_CP = 8
);
    import cellrv32_package::*;

    logic                   req_i;
    logic [CP_ID_W-1:0]     cp_id_i;
    logic                   kill_i;
    logic [NUM_CP-1:0]      cp_start_o;
    logic [NUM_CP-1:0]      cp_valid_i;
    logic [NUM_CP*XLEN-1:0] cp_res_i;
    logic [XLEN-1:0]        res_o;
    logic                   done_o;
    logic                   timeout_o;
    logic                   illegal_o;
    logic                   busy_o;
    dispatch_state_t        dbg_state_o;

    // Dispatcher side.
    modport slave (
        input  req_i, cp_id_i, kill_i, cp_valid_i, cp_res_i,
        output cp_start_o, res_o, done_o, timeout_o, illegal_o, busy_o, dbg_state_o
    );

    // Control unit / co-processor array side.
    modport master (
        output req_i, cp_id_i, kill_i, cp_valid_i, cp_res_i,
        input  cp_start_o, res_o, done_o, timeout_o, illegal_o, busy_o, dbg_state_o
    );

endinterface

// File: rtl/cellrv32_cp_res_or.sv
// OR-reduction of the flattened co-processor result bus. Idle co-processors
// drive zero, so the OR yields the result of the active unit.
module cellrv32_cp_res_or #(
    parameter int NUM_CP = 8,
    parameter int XLEN   = 32
) (
    input  logic [NUM_CP*XLEN-1:0] i_res_flat,
    output logic [XLEN-1:0]        o_res
);

    // Fold all XLEN-wide slices together.
    always_comb begin
        o_res = '0;
        for (int k = 0; k < NUM_CP; k++) begin
            o_res = o_res | i_res_flat[k*XLEN +: XLEN];
        end
    end

endmodule

// File: rtl/cellrv32_cpu_cp_dispatch.sv
// CPU-side co-processor initiator: start pulse, wait for valid with timeout,
// capture the OR-combined result and report done / timeout / illegal select.
module cellrv32_cpu_cp_dispatch
    import cellrv32_package::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_CP  = 8,
    parameter int TMO_CYC = 15
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    cellrv32_cpu_cp_dispatch_if.slave    bus
);

    localparam int                CNT_W    = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TMO_CYC - 1);

    dispatch_state_t        r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CP_ID_W-1:0]     r_id;
    logic [NUM_CP-1:0]      r_start;
    logic [XLEN-1:0]        r_res;
    logic                   r_done;
    logic                   r_tmo;
    logic                   r_ill;

    dispatch_state_t        w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CP_ID_W-1:0]     w_id_nxt;
    logic [NUM_CP-1:0]      w_start_nxt;
    logic [XLEN-1:0]        w_res_nxt;
    logic                   w_done_nxt;
    logic                   w_tmo_nxt;
    logic                   w_ill_nxt;
    logic                   w_sel_valid;
    logic                   w_id_legal;
    logic [XLEN-1:0]        w_res_or;

    cellrv32_cp_res_or #(
        .NUM_CP (NUM_CP),
        .XLEN   (XLEN)
    ) u_res_or (
        .i_res_flat (bus.cp_res_i),
        .o_res      (w_res_or)
    );

    assign w_id_legal = ({1'b0, bus.cp_id_i} < 5'(NUM_CP));

    // Pick the valid bit of the latched co-processor; all others are ignored.
    always_comb begin
        w_sel_valid = 1'b0;
        for (int k = 0; k < NUM_CP; k++) begin
            if (r_id == CP_ID_W'(k)) begin
                w_sel_valid = bus.cp_valid_i[k];
            end
        end
    end

    // Next-state and next-pulse logic; kill overrides everything, valid beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_id_nxt    = r_id;
        w_start_nxt = '0;
        w_res_nxt   = r_res;
        w_done_nxt  = 1'b0;
        w_tmo_nxt   = 1'b0;
        w_ill_nxt   = 1'b0;
        if (bus.kill_i) begin
            w_state_nxt = DISP_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                DISP_IDLE: begin
                    if (bus.req_i) begin
                        if (w_id_legal) begin
                            w_id_nxt    = bus.cp_id_i;
                            w_cnt_nxt   = '0;
                            w_state_nxt = DISP_EXEC;
                            for (int k = 0; k < NUM_CP; k++) begin
                                w_start_nxt[k] = (bus.cp_id_i == CP_ID_W'(k));
                            end
                        end else begin
                            w_ill_nxt = 1'b1;
                        end
                    end
                end
                DISP_EXEC: begin
                    if (r_cnt != CNT_LAST) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    if (w_sel_valid) begin
                        w_state_nxt = DISP_CAPT;
                    end else if (r_cnt == CNT_LAST) begin
                        w_tmo_nxt   = 1'b1;
                        w_state_nxt = DISP_IDLE;
                    end
                end
                DISP_CAPT: begin
                    w_res_nxt   = w_res_or;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DISP_IDLE;
                end
                default: begin
                    w_state_nxt = DISP_IDLE;
                end
            endcase
        end
    end

    // State, counter, latched id, captured result and status pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= DISP_IDLE;
            r_cnt   <= '0;
            r_id    <= '0;
            r_start <= '0;
            r_res   <= '0;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_id    <= w_id_nxt;
            r_start <= w_start_nxt;
            r_res   <= w_res_nxt;
            r_done  <= w_done_nxt;
            r_tmo   <= w_tmo_nxt;
            r_ill   <= w_ill_nxt;
        end
    end

    assign bus.cp_start_o  = r_start;
    assign bus.res_o       = r_res;
    assign bus.done_o      = r_done;
    assign bus.timeout_o   = r_tmo;
    assign bus.illegal_o   = r_ill;
    assign bus.busy_o      = (r_state != DISP_IDLE);
    assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_cellrv32_cpu_cp_dispatch.sv
// Bench for cellrv32_cpu_cp_dispatch: co-processor model, scoreboard of expected
// status events, per-cycle start/busy checks and directed plus random operations.
module tb_cellrv32_cpu_cp_dispatch;
    import cellrv32_package::*;

    localparam int XLEN    = 32;
    localparam int NUM_CP  = 8;
    localparam int TMO_CYC = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Scoreboard: {done, timeout, illegal, result} and the cycle it must appear.
    logic [XLEN+2:0] exp_q[$];
    int              exp_cyc_q[$];
    logic [XLEN-1:0] last_res = '0;
    int              exp_start_cyc = -1;
    logic [NUM_CP-1:0] exp_start_val = '0;
    int              busy_lo = 1;
    int              busy_hi = 0;

    // Co-processor model state.
    int              plan_id = 0;
    int              plan_k = -1;
    logic [XLEN-1:0] plan_res = '0;
    int              act_id = 0;
    int              act_v = -10;
    logic [XLEN-1:0] act_res = '0;
    logic [NUM_CP-1:0] stray_mask = '0;
    logic [NUM_CP-1:0] m_valid;
    logic [NUM_CP*XLEN-1:0] m_res;

    logic [XLEN+2:0] e;
    int              ec;
    logic [2:0]      evt;

    cellrv32_cpu_cp_dispatch_if #(.XLEN(XLEN), .NUM_CP(NUM_CP)) bus ();

    cellrv32_cpu_cp_dispatch #(
        .XLEN    (XLEN),
        .NUM_CP  (NUM_CP),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Co-processor array model: on start, schedule valid k cycles later and
    // drive the result in the valid cycle and the one after it.
    always @(negedge clk) begin
        if (bus.cp_start_o != '0) begin
            act_id  = plan_id;
            act_res = plan_res;
            act_v   = (plan_k < 0) ? -10 : cyc + plan_k;
        end
        m_valid = stray_mask;
        m_res   = '0;
        if (act_v >= 0 && cyc == act_v) begin
            m_valid[act_id] = 1'b1;
            m_res[act_id*XLEN +: XLEN] = act_res;
        end
        if (act_v >= 0 && cyc == act_v + 1) begin
            m_res[act_id*XLEN +: XLEN] = act_res;
        end
        bus.cp_valid_i = m_valid;
        bus.cp_res_i   = m_res;
    end

    // Monitor: busy, start pulse and status events against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 64'(bus.busy_o), 64'((cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0));
            if (bus.cp_start_o != '0 || cyc == exp_start_cyc) begin
                chk("start", 64'(bus.cp_start_o),
                    64'((cyc == exp_start_cyc) ? exp_start_val : {NUM_CP{1'b0}}));
            end
            evt = {bus.done_o, bus.timeout_o, bus.illegal_o};
            if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
                chk("missed_evt", 64'(cyc), 64'(exp_cyc_q[0]));
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (evt != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_evt", 64'(evt), 64'(0));
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    chk("evt_kind", 64'(evt), 64'(e[XLEN+2:XLEN]));
                    chk("evt_cycle", 64'(cyc), 64'(ec));
                    if (e[XLEN+2]) begin
                        chk("res", 64'(bus.res_o), 64'(e[XLEN-1:0]));
                        last_res = e[XLEN-1:0];
                    end else begin
                        chk("res_hold", 64'(bus.res_o), 64'(last_res));
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one request at the current negedge and record what must follow.
    task automatic issue(input int id, input int k, input logic [XLEN-1:0] r);
        int n;
        n = cyc;
        bus.req_i   = 1'b1;
        bus.cp_id_i = CP_ID_W'(id);
        plan_id  = id;
        plan_k   = k;
        plan_res = r;
        if (id >= NUM_CP) begin
            exp_q.push_back({3'b001, {XLEN{1'b0}}});
            exp_cyc_q.push_back(n + 1);
        end else begin
            exp_start_cyc = n + 1;
            exp_start_val = NUM_CP'(1) << id;
            busy_lo = n + 1;
            if (k < 0 || k > TMO_CYC - 1) begin
                exp_q.push_back({3'b010, {XLEN{1'b0}}});
                exp_cyc_q.push_back(n + 1 + TMO_CYC);
                busy_hi = n + TMO_CYC;
            end else begin
                exp_q.push_back({3'b100, r});
                exp_cyc_q.push_back(n + 3 + k);
                busy_hi = n + 2 + k;
            end
        end
        @(negedge clk);
        bus.req_i = 1'b0;
    endtask

    // Abort the running operation; nothing further is expected from it.
    task automatic kill_op();
        bus.kill_i = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        busy_hi = cyc;
        @(negedge clk);
        bus.kill_i = 1'b0;
        chk("kill_state", 64'(bus.dbg_state_o), 64'(DISP_IDLE));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 64'(bus.cp_start_o), 64'(0));
        chk({tag, "_res"}, 64'(bus.res_o), 64'(0));
        chk({tag, "_done"}, 64'(bus.done_o), 64'(0));
        chk({tag, "_tmo"}, 64'(bus.timeout_o), 64'(0));
        chk({tag, "_ill"}, 64'(bus.illegal_o), 64'(0));
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'(0));
        chk({tag, "_state"}, 64'(bus.dbg_state_o), 64'(DISP_IDLE));
    endtask

    initial begin
        int id;
        int k;
        logic [XLEN-1:0] r;

        bus.req_i   = 1'b0;
        bus.cp_id_i = '0;
        bus.kill_i  = 1'b0;
        rst = 1'b1;
        wait_cyc(3);
        chk_all_zero("reset");
        rst = 1'b0;
        wait_cyc(2);

        // Single-cycle co-processor.
        issue(3, 0, 32'h1234_5678);
        wait_cyc(4);

        // Multi-cycle co-processor.
        issue(1, 5, 32'hDEAD_BEEF);
        wait_cyc(9);

        // Timeout, then a new request right on the timeout cycle.
        issue(2, -1, 32'h0);
        wait_cyc(TMO_CYC);
        issue(4, 1, 32'hA5A5_0F0F);
        wait_cyc(6);

        // Illegal selects.
        issue(9, 0, 32'h0);
        wait_cyc(2);
        issue(15, 0, 32'h0);
        wait_cyc(2);

        // Kill mid-operation; the late valid must be ignored.
        issue(0, 4, 32'h0BAD_F00D);
        wait_cyc(2);
        kill_op();
        wait_cyc(6);
        chk("kill_res_hold", 64'(bus.res_o), 64'(last_res));

        // Valid on the last cycle before timeout.
        issue(5, TMO_CYC - 1, 32'h600D_CAFE);
        wait_cyc(TMO_CYC + 3);

        // Stray valids from unselected co-processors.
        stray_mask = 8'b1000_0001;
        issue(2, 3, 32'h0F0F_1234);
        wait_cyc(6);
        stray_mask = '0;
        wait_cyc(1);

        // Back-to-back: second request on the done cycle.
        issue(6, 0, 32'h1111_2222);
        wait_cyc(2);
        issue(7, 2, 32'h3333_4444);
        wait_cyc(7);

        // Kill together with a request in IDLE drops the request.
        bus.req_i   = 1'b1;
        bus.kill_i  = 1'b1;
        bus.cp_id_i = 4'd2;
        @(negedge clk);
        bus.req_i  = 1'b0;
        bus.kill_i = 1'b0;
        wait_cyc(3);

        // Random operations, each next request issued as soon as IDLE is seen.
        for (int t = 0; t < 10; t++) begin
            id = int'($urandom_range(0, 10));
            k  = int'($urandom_range(0, 18)) - 1;
            r  = $urandom;
            issue(id, k, r);
            if (id >= NUM_CP) wait_cyc(0);
            else if (k < 0 || k > TMO_CYC - 1) wait_cyc(TMO_CYC);
            else wait_cyc(k + 2);
        end
        wait_cyc(4);

        // Asynchronous reset during EXEC.
        issue(3, -1, 32'h0);
        wait_cyc(3);
        #2;
        rst = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        busy_hi = cyc;
        exp_start_cyc = -1;
        last_res = '0;
        #1;
        chk_all_zero("async_rst");
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(3);
        issue(1, 0, 32'hCAFE_0001);
        wait_cyc(5);

        // Drain any outstanding expectations with a bounded wait.
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) chk("drain", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cellrv32_cpu_cp_dispatch.md
Name: cellrv32_cpu_cp_dispatch

Overview:
- CPU-side initiator for the co-processor interface. It accepts an issue request from the control unit, fires a one-cycle start pulse to the selected co-processor and waits for that co-processor's valid.
- It then captures the OR-combined co-processor result and reports done, timeout or illegal-select back to the control unit.
- It sits between the CPU control FSM and the co-processor array (shift, mul/div, bit-manip, Zicond, ...).

Parameters:
XLEN, 32, data path width
NUM_CP, 8, number of attached co-processors (1..16)
TMO_CYC, 15, maximum cycles in EXEC waiting for valid before timeout (1..255)

Ports:
clk_i  in  1  global clock, rising edge
rst_i  in  1  asynchronous active-high reset
req_i  in  1  issue request, sampled only in IDLE
cp_id_i  in  4  co-processor index, sampled with req_i
kill_i  in  1  abort (trap/flush), highest priority
cp_start_o  out  NUM_CP  one-hot start pulse, registered
cp_valid_i  in  NUM_CP  per-co-processor valid
cp_res_i  in  NUM_CP*XLEN  flattened results; slice k = bits [k*XLEN +: XLEN]; an idle co-processor drives zero
res_o  out  XLEN  captured result
done_o  out  1  one-cycle pulse, res_o valid
timeout_o  out  1  one-cycle pulse, no valid within TMO_CYC
illegal_o  out  1  one-cycle pulse, cp_id_i >= NUM_CP
busy_o  out  1  high in EXEC and CAPT

Behaviour:
- Reset: state=IDLE, cp_start_o=0, res_o=0, done_o=0, timeout_o=0, illegal_o=0, counter=0, latched id=0.
- States: IDLE, EXEC, CAPT. busy_o=1 in EXEC and CAPT.
- IDLE:
  - req_i=1 with cp_id_i < NUM_CP: latch id, clear counter, go to EXEC, and cp_start_o[id]=1 in the first EXEC cycle only.
  - req_i=1 with cp_id_i >= NUM_CP: illegal_o=1 next cycle, stay in IDLE, no start.
- EXEC:
  - Counter increments each cycle.
  - cp_valid_i[id]=1: go to CAPT.
  - Otherwise, when counter reaches TMO_CYC-1: timeout_o=1 next cycle, res_o unchanged, go to IDLE.
  - Valid in the same cycle as timeout: valid wins.
  - Valid may coincide with the start cycle, as for single-cycle co-processors.
  - Valid from non-selected co-processors is ignored.
- CAPT (exactly one cycle): res_o <= OR of all cp_res_i slices; done_o=1 next cycle; go to IDLE.
- Latency from req_i at cycle N:
  - Start at N+1.
  - Single-cycle co-processor (valid at N+1): CAPT at N+2, done_o and res_o at N+3.
  - Valid at N+1+k: done at N+3+k.
- req_i in EXEC or CAPT is ignored; the control unit must hold off while busy_o=1.
- req_i in the cycle done_o is high (state already IDLE) is accepted.
- kill_i=1 in any state: next state IDLE, counter cleared, cp_start_o cleared.
  - A pending done or timeout for the killed op is suppressed.
  - res_o keeps its old value.
  - kill_i together with req_i in IDLE: the request is dropped.
- Async reset mid-operation: immediate return to reset values. No start pulse may be generated during reset or in the cycle after release unless req_i was sampled.
- Status pulses done_o, timeout_o and illegal_o are mutually exclusive and each is at most one cycle.
- Counter width is $clog2(TMO_CYC+1) and it never wraps; it is reset on each EXEC entry.

Decomposition:
- Shared package (cellrv32_package): dispatch state enum type; constant for the cp_id_i width (4); co-processor index constants (CP_SEL_SHIFT, CP_SEL_MULDIV, CP_SEL_BITMANIP, CP_SEL_COND, ...).
- One sub-module, cellrv32_cp_res_or: parameterised NUM_CP x XLEN OR-reduction of the flattened result bus. It is combinational and is instantiated once.
- The FSM, counter and pulse registers stay in the top module.

Test Plan:
- Single-cycle co-processor: NUM_CP=8; req_i at cycle 0 with id=3; model asserts cp_valid_i[3] in the same cycle as start and slice 3 = 0x12345678 in the next cycle. Required: cp_start_o=8'b0000_1000 at cycle 1 only; done_o at cycle 3; res_o=0x12345678.
- Multi-cycle co-processor: id=1 with valid 5 cycles after start, result 0xDEADBEEF. Required: busy_o high for cycles 1..7; done_o at cycle 8; res_o=0xDEADBEEF.
- Timeout: TMO_CYC=15, id=2, valid never asserted. Required: timeout_o pulses exactly 16 cycles after req; done_o never pulses; a new req is accepted in the following cycle.
- Illegal select: NUM_CP=4, req with id=6. Required: illegal_o at cycle 1; cp_start_o=0 throughout; busy_o stays 0.
- Kill mid-op: id=0 with valid planned at start+4; kill_i at start+2. Required: state IDLE at start+3; no done_o or timeout_o; late valid ignored; res_o unchanged.
- Corner cases:
  - Valid on the last timeout cycle: done_o only.
  - Stray valid from an unselected co-processor: ignored.
  - Back-to-back requests issued on the done_o cycle: both complete.
  - Async reset asserted during EXEC: all outputs return to 0 immediately.
